dcm_reconfig_ctrl: RTL and testbench

Sequencer that owns run-time reprogramming of the clock manager feeding the producer/consumer clock domains. On an `update` request it pauses the producers and waits for the CDC buffer and display path to drain. It then applies the new program word to the clock manager in a single strobe and waits a fixed settle interval before releasing the producers. It sits in the board-clock domain, between the top-level FSM, the clock manager and the CDC wrapper.

---
 rtl/dcm_ctrl_pkg.sv | 18 +
 rtl/cycle_counter.sv | 32 +++
 rtl/dcm_reconfig_ctrl.sv | 144 ++++++++++++++
 tb/tb_dcm_reconfig_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dcm_ctrl_pkg.sv
// Shared types and defaults for the clock-manager reconfiguration sequencer.
package dcm_ctrl_pkg;

  localparam int unsigned PROG_W = 3;

  localparam logic [PROG_W-1:0] PROG_RESET_DEF    = 3'b000;
  localparam int unsigned       DRAIN_STABLE_DEF  = 2;
  localparam int unsigned       DRAIN_TIMEOUT_DEF = 1024;
  localparam int unsigned       SETTLE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } dcm_state_e;

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter; done_o is high while the count sits at LIMIT.
module cycle_counter #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (en_i && (count_q != LIMIT_C))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign done_o = (count_q == LIMIT_C);

endmodule

// File: rtl/dcm_reconfig_ctrl.sv
// Pauses producers, waits for the CDC path to drain, strobes a new program word
// into the clock manager, then holds producers for a fixed settle interval.
module dcm_reconfig_ctrl
  import dcm_ctrl_pkg::*;
#(
  parameter logic [PROG_W-1:0] PROG_RESET    = PROG_RESET_DEF,
  parameter int unsigned       DRAIN_STABLE  = DRAIN_STABLE_DEF,
  parameter int unsigned       DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter int unsigned       SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              update,
  input  logic [PROG_W-1:0] prog_in,
  input  logic              buffer_empty,
  input  logic              data_2_valid,
  output logic              hold,
  output logic [PROG_W-1:0] prog_out,
  output logic              prog_load,
  output logic              busy,
  output logic              timeout
);

  dcm_state_e        state_q, state_d;
  logic [PROG_W-1:0] pend_q, pend_d;
  logic [PROG_W-1:0] prog_out_q, prog_out_d;
  logic [PROG_W-1:0] prog_q, prog_d;
  logic              req_q, req_d;
  logic              timeout_q, timeout_d;

  logic              drained;
  logic              stable_done, tmo_done, settle_done;
  logic [PROG_W-1:0] pend_eff, queue_val;
  logic              queue_req;

  assign drained = buffer_empty & ~data_2_valid;

  // Timeout and settle limits are one less than the cycle counts because the
  // exit decision is taken on the edge after the counter reaches its limit.
  cycle_counter #(.LIMIT(DRAIN_STABLE)) u_stable (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i ((state_q != ST_DRAIN) || !drained),
    .en_i    (drained),
    .done_o  (stable_done)
  );

  cycle_counter #(.LIMIT(DRAIN_TIMEOUT - 1)) u_timeout (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (state_q != ST_DRAIN),
    .en_i    (1'b1),
    .done_o  (tmo_done)
  );

  cycle_counter #(.LIMIT(SETTLE_CYCLES - 1)) u_settle (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (state_q != ST_SETTLE),
    .en_i    (1'b1),
    .done_o  (settle_done)
  );

  // A request arriving on the deciding edge is folded in rather than dropped.
  assign pend_eff  = update ? prog_in : pend_q;
  assign queue_req = req_q | update;
  assign queue_val = update ? prog_in : prog_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    prog_out_d = prog_out_q;
    prog_d     = prog_q;
    req_d      = req_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (update && (prog_in != prog_out_q)) begin
          pend_d    = prog_in;
          timeout_d = 1'b0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pend_d = pend_eff;
        if (stable_done) begin
          prog_out_d = pend_eff;
          state_d    = ST_APPLY;
        end else if (tmo_done) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_APPLY: begin
        state_d = ST_SETTLE;
        if (update) begin
          req_d  = 1'b1;
          prog_d = prog_in;
        end
      end
      ST_SETTLE: begin
        if (update) begin
          req_d  = 1'b1;
          prog_d = prog_in;
        end
        if (settle_done) begin
          req_d = 1'b0;
          if (queue_req && (queue_val != prog_out_q)) begin
            pend_d  = queue_val;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= PROG_RESET;
      prog_out_q <= PROG_RESET;
      prog_q     <= PROG_RESET;
      req_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      prog_out_q <= prog_out_d;
      prog_q     <= prog_d;
      req_q      <= req_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hold      = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign prog_load = (state_q == ST_APPLY);
  assign prog_out  = prog_out_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_dcm_reconfig_ctrl.sv
// Directed bench for dcm_reconfig_ctrl with default parameters.
module tb_dcm_reconfig_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       update = 1'b0;
  logic [2:0] prog_in = 3'b000;
  logic       buffer_empty = 1'b1;
  logic       data_2_valid = 1'b0;
  logic       hold;
  logic [2:0] prog_out;
  logic       prog_load;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  dcm_reconfig_ctrl #(
    .PROG_RESET    (3'b000),
    .DRAIN_STABLE  (2),
    .DRAIN_TIMEOUT (1024),
    .SETTLE_CYCLES (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .update       (update),
    .prog_in      (prog_in),
    .buffer_empty (buffer_empty),
    .data_2_valid (data_2_valid),
    .hold         (hold),
    .prog_out     (prog_out),
    .prog_load    (prog_load),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_count();
    step();
    if (prog_load) pulses++;
  endtask

  task automatic pulse_update(input logic [2:0] val);
    update  = 1'b1;
    prog_in = val;
    step();
    update  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (!busy) break;
      step();
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values while reset is held low
    #2;
    check("rst_prog_out", 32'(prog_out), 32'h0);
    check("rst_hold", 32'(hold), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_prog_load", 32'(prog_load), 32'h0);
    step();
    step();
    reset = 1'b1;
    step();

    // Request equal to current word is ignored
    pulse_update(3'b000);
    check("same_busy", 32'(busy), 32'h0);
    step();
    check("same_busy2", 32'(busy), 32'h0);

    // Nominal: drained already, prog_load after N+3, hold falls after N+20
    pulse_update(3'b101);
    check("nom_busy_n", 32'(busy), 32'h1);
    check("nom_hold_n", 32'(hold), 32'h1);
    step();
    check("nom_load_n1", 32'(prog_load), 32'h0);
    step();
    check("nom_load_n2", 32'(prog_load), 32'h0);
    check("nom_out_n2", 32'(prog_out), 32'h0);
    step();
    check("nom_load_n3", 32'(prog_load), 32'h1);
    check("nom_out_n3", 32'(prog_out), 32'h5);
    step();
    check("nom_load_n4", 32'(prog_load), 32'h0);
    check("nom_hold_n4", 32'(hold), 32'h1);
    repeat (15) step();
    check("nom_hold_n19", 32'(hold), 32'h1);
    step();
    check("nom_hold_n20", 32'(hold), 32'h0);
    check("nom_busy_n20", 32'(busy), 32'h0);
    check("nom_out_final", 32'(prog_out), 32'h5);

    // Slow drain with a data_2_valid glitch restarting the stable count
    buffer_empty = 1'b0;
    pulse_update(3'b010);
    repeat (50) step();
    check("slow_busy_n50", 32'(busy), 32'h1);
    check("slow_out_n50", 32'(prog_out), 32'h5);
    buffer_empty = 1'b1;
    step();
    data_2_valid = 1'b1;
    step();
    data_2_valid = 1'b0;
    step();
    check("slow_load_n53", 32'(prog_load), 32'h0);
    step();
    check("slow_load_n54", 32'(prog_load), 32'h0);
    step();
    check("slow_load_n55", 32'(prog_load), 32'h1);
    check("slow_out_n55", 32'(prog_out), 32'h2);
    wait_idle("slow_idle");

    // Drain timeout after 1024 cycles in DRAIN
    buffer_empty = 1'b0;
    pulse_update(3'b111);
    repeat (1023) step();
    check("tmo_busy_n1023", 32'(busy), 32'h1);
    check("tmo_flag_n1023", 32'(timeout), 32'h0);
    step();
    check("tmo_flag_n1024", 32'(timeout), 32'h1);
    check("tmo_hold_n1024", 32'(hold), 32'h0);
    check("tmo_busy_n1024", 32'(busy), 32'h0);
    check("tmo_out", 32'(prog_out), 32'h2);
    buffer_empty = 1'b1;
    pulse_update(3'b010);
    check("tmo_ignored_flag", 32'(timeout), 32'h1);
    check("tmo_ignored_busy", 32'(busy), 32'h0);
    pulse_update(3'b100);
    check("tmo_cleared", 32'(timeout), 32'h0);
    check("tmo_accept_busy", 32'(busy), 32'h1);
    wait_idle("tmo_idle");
    check("tmo_final_out", 32'(prog_out), 32'h4);

    // Queued requests during SETTLE; last one equals prog_out so no second load
    pulses = 0;
    pulse_update(3'b011);
    repeat (5) step_count();
    update = 1'b1; prog_in = 3'b110;
    step_count();
    update = 1'b0;
    step_count();
    update = 1'b1; prog_in = 3'b011;
    step_count();
    update = 1'b0;
    repeat (11) step_count();
    check("q_busy_n19", 32'(busy), 32'h1);
    step_count();
    check("q_busy_n20", 32'(busy), 32'h0);
    repeat (10) step_count();
    check("q_busy_late", 32'(busy), 32'h0);
    check("q_pulses", 32'(pulses), 32'd1);
    check("q_out", 32'(prog_out), 32'h3);

    // Reset asserted mid-SETTLE
    pulse_update(3'b101);
    repeat (6) step();
    check("mid_hold_pre", 32'(hold), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_hold", 32'(hold), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_load", 32'(prog_load), 32'h0);
    check("mid_out", 32'(prog_out), 32'h0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
